// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | alu_muldiv_seq: shift-add MUL and restoring DIVU/REMU sequenced over the     |
// | shared Alu using only its ADD, SUB and SLTU operations.   Rev 1.0            |
// +-----------------------------------------------------------------------------+
module alu_muldiv_seq #(
   parameter int         XLEN    = 32,
   parameter logic [3:0] OP_ADD  = 4'b0000,
   parameter logic [3:0] OP_SUB  = 4'b0001,
   parameter logic [3:0] OP_SLTU = 4'b1100
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_op,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_res,
   output logic            alu_own,
   output logic [3:0]      alu_op,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   input  logic [XLEN-1:0] alu_res
);

   localparam int                c_cnt_w    = $clog2(XLEN);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(XLEN - 1);
   localparam logic [1:0]        c_op_mul   = 2'b00;
   localparam logic [1:0]        c_op_divu  = 2'b01;
   localparam logic [1:0]        c_op_remu  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_MUL_ADD = 3'd1,
      S_DIV_CMP = 3'd2,
      S_DIV_SUB = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t             r_state;
   logic [XLEN-1:0]    r_acc;
   logic [XLEN-1:0]    r_mcand;
   logic [XLEN-1:0]    r_quot;      // multiplier while multiplying, quotient while dividing
   logic [XLEN-1:0]    r_rem;
   logic               r_rem_top;
   logic [XLEN-1:0]    r_divisor;
   logic [c_cnt_w-1:0] r_cnt;
   logic [1:0]         r_op_q;
   logic               r_in_ready;
   logic               r_out_valid;
   logic [XLEN-1:0]    r_out_res;
   logic               r_alu_own;

   logic [XLEN-1:0]    w_acc_mul;
   logic [XLEN-1:0]    w_shift;
   logic               w_ge;
   logic [XLEN-1:0]    w_rem_sub;
   logic [XLEN-1:0]    w_quot_sub;

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_res   = r_out_res;
   assign alu_own   = r_alu_own;

   // The 33-bit partial remainder is {rem_top, rem}; the carry bit makes ge true outright.
   always_comb begin
      w_acc_mul  = r_quot[0] ? alu_res : r_acc;
      w_shift    = {r_rem[XLEN-2:0], r_quot[XLEN-1]};
      w_ge       = r_rem[XLEN-1] | ~alu_res[0];
      w_rem_sub  = r_rem_top ? alu_res : r_rem;
      w_quot_sub = {r_quot[XLEN-1:1], r_quot[0] | r_rem_top};
      alu_op     = OP_ADD;
      alu_a      = '0;
      alu_b      = '0;
      case (r_state)
         S_MUL_ADD: begin
            alu_op = OP_ADD;
            alu_a  = r_acc;
            alu_b  = r_mcand;
         end
         S_DIV_CMP: begin
            alu_op = OP_SLTU;
            alu_a  = w_shift;
            alu_b  = r_divisor;
         end
         S_DIV_SUB: begin
            alu_op = OP_SUB;
            alu_a  = r_rem;
            alu_b  = r_divisor;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_mcand     <= '0;
         r_quot      <= '0;
         r_rem       <= '0;
         r_rem_top   <= 1'b0;
         r_divisor   <= '0;
         r_cnt       <= '0;
         r_op_q      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_res   <= '0;
         r_alu_own   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_in_ready <= 1'b0;
                  r_op_q     <= in_op;
                  r_cnt      <= '0;
                  case (in_op)
                     c_op_mul: begin
                        r_acc     <= '0;
                        r_mcand   <= in_a;
                        r_quot    <= in_b;
                        r_alu_own <= 1'b1;
                        r_state   <= S_MUL_ADD;
                     end
                     c_op_divu, c_op_remu: begin
                        r_quot    <= in_a;
                        r_rem     <= '0;
                        r_rem_top <= 1'b0;
                        r_divisor <= in_b;
                        r_alu_own <= 1'b1;
                        r_state   <= S_DIV_CMP;
                     end
                     default: begin
                        r_acc       <= '0;
                        r_out_res   <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                     end
                  endcase
               end
            end
            S_MUL_ADD: begin
               r_acc   <= w_acc_mul;
               r_mcand <= r_mcand << 1;
               r_quot  <= r_quot >> 1;
               r_cnt   <= r_cnt + 1'b1;
               if (r_cnt == c_cnt_last) begin
                  r_alu_own   <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_out_res   <= w_acc_mul;
                  r_state     <= S_DONE;
               end
            end
            S_DIV_CMP: begin
               r_rem     <= w_shift;
               r_rem_top <= w_ge;
               r_quot    <= r_quot << 1;
               r_state   <= S_DIV_SUB;
            end
            S_DIV_SUB: begin
               r_rem  <= w_rem_sub;
               r_quot <= w_quot_sub;
               r_cnt  <= r_cnt + 1'b1;
               if (r_cnt == c_cnt_last) begin
                  r_alu_own   <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_out_res   <= (r_op_q == c_op_remu) ? w_rem_sub : w_quot_sub;
                  r_state     <= S_DONE;
               end else begin
                  r_state <= S_DIV_CMP;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_alu_muldiv_seq: vector table and scoreboard bench for alu_muldiv_seq,     |
// | with a behavioural Alu model closing the loop.   Rev 1.0                     |
// +-----------------------------------------------------------------------------+
module tb_alu_muldiv_seq;

   localparam logic [3:0] c_add  = 4'b0000;
   localparam logic [3:0] c_sub  = 4'b0001;
   localparam logic [3:0] c_sltu = 4'b1100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_op = 2'b00;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_res;
   logic        alu_own;
   logic [3:0]  alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_res;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] sbq[$];

   typedef struct packed {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] e;
   } vec_t;
   vec_t vecs[14];

   alu_muldiv_seq dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
      .alu_own(alu_own), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res)
   );

   always #5 clk = ~clk;

   always_comb begin
      case (alu_op)
         c_add:   alu_res = alu_a + alu_b;
         c_sub:   alu_res = alu_a - alu_b;
         c_sltu:  alu_res = {31'd0, alu_a < alu_b};
         default: alu_res = 32'hDEAD_BEEF;
      endcase
   end

   function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [63:0] p;
      case (op)
         2'b00:   begin p = 64'(a) * 64'(b); ref_model = p[31:0]; end
         2'b01:   ref_model = (b == 0) ? 32'hFFFF_FFFF : a / b;
         2'b10:   ref_model = (b == 0) ? a : a % b;
         default: ref_model = 32'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
      in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
      @(posedge clk);
      sbq.push_back(e);
      #1;
      in_valid = 1'b0;
      in_a = $urandom;
      in_b = $urandom;
   endtask

   // Waits for the result counting edges since accept, checks Alu sequencing, then handshakes.
   task automatic collect(input string name, input int exp_lat, input logic [3:0] first_op,
                          input bit alternate, input int hold);
      int          n = 1;
      bit          alu_bad = 1'b0;
      bit          hold_bad = 1'b0;
      logic [3:0]  want = first_op;
      logic [31:0] held;
      @(negedge clk);
      while (!out_valid && n < 200) begin
         if (!alu_own || alu_op !== want || in_ready) alu_bad = 1'b1;
         if (alternate) want = (want == c_sltu) ? c_sub : c_sltu;
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      check({name, "_latency"}, 32'(n), 32'(exp_lat));
      check({name, "_alu_seq_ok"}, {31'd0, alu_bad}, 32'd0);
      check({name, "_done_alu_idle"}, {alu_own, alu_op, alu_a[3:0] | alu_b[3:0]}, 9'd0);
      if (!out_valid) begin
         sbq.delete();
         return;
      end
      if (sbq.size() == 0) begin
         check({name, "_scoreboard_empty"}, 32'd1, 32'd0);
      end else begin
         check({name, "_result"}, out_res, sbq.pop_front());
      end
      held = out_res;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         in_op = 2'b00;
         @(posedge clk);
         @(negedge clk);
         if (!out_valid || out_res !== held || in_ready) hold_bad = 1'b1;
      end
      in_valid = 1'b0;
      if (hold > 0) check({name, "_hold_stable_bad"}, {31'd0, hold_bad}, 32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check({name, "_after_handshake"}, {30'd0, in_ready, out_valid}, 32'b10);
   endtask

   function automatic int lat_of(input logic [1:0] op);
      return (op == 2'b00) ? 33 : (op == 2'b11) ? 1 : 65;
   endfunction

   initial begin
      vecs[0]  = '{op: 2'b00, a: 32'd7,          b: 32'd6,          e: 32'd42};
      vecs[1]  = '{op: 2'b00, a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  e: 32'd1};
      vecs[2]  = '{op: 2'b01, a: 32'd100,        b: 32'd7,          e: 32'd14};
      vecs[3]  = '{op: 2'b10, a: 32'd100,        b: 32'd7,          e: 32'd2};
      vecs[4]  = '{op: 2'b01, a: 32'hFFFF_FFFF,  b: 32'h8000_0000,  e: 32'd1};
      vecs[5]  = '{op: 2'b10, a: 32'hFFFF_FFFF,  b: 32'h8000_0000,  e: 32'h7FFF_FFFF};
      vecs[6]  = '{op: 2'b01, a: 32'd5,          b: 32'd0,          e: 32'hFFFF_FFFF};
      vecs[7]  = '{op: 2'b10, a: 32'd5,          b: 32'd0,          e: 32'd5};
      vecs[8]  = '{op: 2'b11, a: 32'd12,         b: 32'd34,         e: 32'd0};
      vecs[9]  = '{op: 2'b00, a: 32'h1234_5678,  b: 32'h9ABC_DEF0,  e: 32'd0};
      vecs[10] = '{op: 2'b01, a: 32'hDEAD_BEEF,  b: 32'h0000_1234,  e: 32'd0};
      vecs[11] = '{op: 2'b10, a: 32'hDEAD_BEEF,  b: 32'h0000_1234,  e: 32'd0};
      vecs[12] = '{op: 2'b01, a: 32'd1,          b: 32'hFFFF_FFFF,  e: 32'd0};
      vecs[13] = '{op: 2'b10, a: 32'hC000_0001,  b: 32'h4000_0000,  e: 32'd0};
      for (int i = 9; i < 14; i++) vecs[i].e = ref_model(vecs[i].op, vecs[i].a, vecs[i].b);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_flags", {29'd0, in_ready, out_valid, alu_own}, 32'b100);
      check("reset_out_res", out_res, 32'd0);
      check("reset_alu_drive", {alu_op, alu_a[27:0] | alu_b[27:0]}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e);
         collect($sformatf("vec%0d", i), lat_of(vecs[i].op),
                 (vecs[i].op == 2'b00) ? c_add : c_sltu, vecs[i].op != 2'b00, 0);
      end

      issue(2'b00, 32'd7, 32'd6, 32'd42);
      collect("mul_hold", 33, c_add, 1'b0, 10);

      issue(2'b01, 32'd1000, 32'd3, 32'd333);
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midop_reset_flags", {29'd0, in_ready, out_valid, alu_own}, 32'b100);
      sbq.delete();
      rst_n = 1'b1;
      repeat (80) @(negedge clk) begin
         if (out_valid) check("no_result_after_reset", {31'd0, out_valid}, 32'd0);
      end
      issue(2'b00, 32'd3, 32'd3, 32'd9);
      collect("mul_after_reset", 33, c_add, 1'b0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

endmodule
`default_nettype wire
